// File: rtl/ntt_coef_collector.sv
// Collects synchronizer words into an N-coefficient block and streams it to the NTT core.
// Define MOD_REDUCE_EN to conditionally subtract Q from each coefficient as it is captured.
module ntt_coef_collector #(
    parameter int WIDTH  = 32,
    parameter int COEF_W = 16,
    parameter int N      = 16,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              busy,
    output logic              out_valid,
    output logic [COEF_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              ovf
);
    localparam int P      = WIDTH / COEF_W;
    localparam int NW     = N / P;
    localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NW - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

    if ((WIDTH % COEF_W) != 0 || (N % P) != 0 || Q >= (1 << COEF_W)) begin : g_bad_cfg
        $error("ntt_coef_collector: invalid parameter set");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_e;

`ifdef MOD_REDUCE_EN
    localparam logic [COEF_W-1:0] Q_C = COEF_W'(Q);

    // One conditional subtraction only: inputs >= 2Q stay partially reduced.
    function automatic logic [COEF_W-1:0] capture_lane(input logic [COEF_W-1:0] c);
        return (c >= Q_C) ? c - Q_C : c;
    endfunction
`else
    function automatic logic [COEF_W-1:0] capture_lane(input logic [COEF_W-1:0] c);
        return c;
    endfunction
`endif

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [COEF_W-1:0]   coef_q [N];
    logic [COEF_W-1:0]   coef_d [N];
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [COEF_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                ovf_q, ovf_d;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        coef_d      = coef_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        ovf_d       = ovf_q | (in_valid & busy_q);

        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    for (int i = 0; i < P; i++) begin
                        coef_d[IDX_W'(int'(wcnt_q) * P + i)] =
                            capture_lane(in_data[i*COEF_W +: COEF_W]);
                    end
                    if (wcnt_q == WCNT_LAST) begin
                        // coef_d[0] rather than coef_q[0]: it may be written this very cycle.
                        state_d     = SEND;
                        wcnt_d      = '0;
                        idx_d       = '0;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b1;
                        out_data_d  = coef_d[0];
                        out_last_d  = (idx_d == IDX_LAST);
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = COLLECT;
                        idx_d       = '0;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        out_data_d = coef_q[idx_d];
                        out_last_d = (idx_d == IDX_LAST);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            wcnt_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: the coefficient buffer is not reset; it is only read after a full block rewrites it.
    always_ff @(posedge clk) begin
        coef_q <= coef_d;
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;
endmodule
